pc_fetch_gen: RTL and testbench

//  Parametrised program-counter generator for the RV32 fetch stage; successor to the plain PC register.

---
 rtl/pc_fetch_gen_pkg.sv | 18 +
 rtl/pc_fetch_gen_if.sv | 25 ++
 rtl/pc_fetch_gen.sv | 77 +++++++
 tb/tb_pc_fetch_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: FSM encoding, default
// widths/vectors and a small target-alignment helper.
package pc_defs;

   localparam int          XLEN_DEF         = 32;
   localparam int          INST_BYTES_DEF   = 4;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PEND = 2'd2;

   function automatic logic is_aligned(input logic [1:0] lo);
      return lo == 2'b00;
   endfunction

endpackage

// File: rtl/pc_fetch_gen_if.sv
// Fetch-side bundle between the PC generator (master) and its consumers
// (instruction memory handshake, branch/trap resolution, stall control).
interface pc_fetch_gen_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic            pc_ready;
   logic            br_taken;
   logic [XLEN-1:0] br_target;
   logic            trap_req;
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic [XLEN-1:0] pc_plus4;
   logic            misalign;

   modport master (
      input  stall, pc_ready, br_taken, br_target, trap_req,
      output pc, pc_valid, pc_plus4, misalign
   );

   modport slave (
      output stall, pc_ready, br_taken, br_target, trap_req,
      input  pc, pc_valid, pc_plus4, misalign
   );
endinterface

// File: rtl/pc_fetch_gen.sv
// RV32 fetch program-counter generator: sequential advance on accepted fetch,
// trap/branch redirect arbitration, and a redirect latch that survives stalls.
module pc_fetch_gen
   import pc_defs::*;
#(
   parameter int              XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
   parameter int              INST_BYTES   = INST_BYTES_DEF
) (
   input logic           clk,
   input logic           rst,
   pc_fetch_gen_if.master bus
);

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_q, pend_d;
   logic            mis_q, mis_d;
   logic            valid;
   logic            fire;
   logic [XLEN-1:0] pc_inc;

   assign valid  = (state_q != ST_BOOT);
   assign fire   = valid & bus.pc_ready & ~bus.stall;
   assign pc_inc = pc_q + XLEN'(INST_BYTES);

   // Redirect priority: trap > branch (misaligned branches become traps) >
   // latched redirect > sequential advance > hold.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      mis_d   = 1'b0;
      if (state_q == ST_BOOT) state_d = ST_RUN;

      if (bus.trap_req) begin
         pc_d    = TRAP_VECTOR;
         state_d = ST_RUN;
      end else if (bus.br_taken && !is_aligned(bus.br_target[1:0])) begin
         mis_d   = 1'b1;
         pc_d    = TRAP_VECTOR;
         state_d = ST_RUN;
      end else if (bus.br_taken && !bus.stall) begin
         pc_d    = bus.br_target;
         state_d = ST_RUN;
      end else if (bus.br_taken) begin
         pend_d  = bus.br_target;
         state_d = ST_PEND;
      end else if (state_q == ST_PEND && !bus.stall) begin
         pc_d    = pend_q;
         state_d = ST_RUN;
      end else if (fire) begin
         pc_d = pc_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_VECTOR;
         pend_q  <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         mis_q   <= mis_d;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.pc_valid = valid;
   assign bus.pc_plus4 = pc_inc;
   assign bus.misalign = mis_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Scoreboard bench for pc_fetch_gen: a cycle-level reference model predicts the
// visible state after each clock edge; a monitor compares it with the DUT.
module tb_pc_fetch_gen;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   typedef struct {
      logic [31:0] pc;
      logic        valid;
      logic        mis;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pc_fetch_gen_if #(.XLEN(32)) bus ();

   pc_fetch_gen #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cycle  = 0;

   // Reference model state: what the fetch address is, whether fetch is
   // offered, and any redirect waiting for the stall to lift.
   logic [31:0] m_pc     = RV;
   logic        m_valid  = 1'b0;
   logic        m_pend_v = 1'b0;
   logic [31:0] m_pend   = '0;

   task automatic model_step(input logic r, input logic stl, input logic rdy,
                             input logic br, input logic [31:0] tgt, input logic trp);
      exp_t e;
      logic accepted;
      logic mis;
      accepted = m_valid && rdy && !stl;
      mis = 1'b0;
      if (r) begin
         m_pc = RV; m_valid = 1'b0; m_pend_v = 1'b0;
      end else begin
         if (trp) begin
            m_pc = TV; m_pend_v = 1'b0;
         end else if (br && tgt[1:0] != 2'b00) begin
            mis = 1'b1; m_pc = TV; m_pend_v = 1'b0;
         end else if (br && !stl) begin
            m_pc = tgt; m_pend_v = 1'b0;
         end else if (br) begin
            m_pend = tgt; m_pend_v = 1'b1;
         end else if (m_pend_v && !stl) begin
            m_pc = m_pend; m_pend_v = 1'b0;
         end else if (accepted) begin
            m_pc = m_pc + 32'd4;
         end
         m_valid = 1'b1;
      end
      e.pc = m_pc; e.valid = m_valid; e.mis = mis;
      q.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic stl, input logic rdy,
                      input logic br, input logic [31:0] tgt, input logic trp);
      @(negedge clk);
      rst           = r;
      bus.stall     = stl;
      bus.pc_ready  = rdy;
      bus.br_taken  = br;
      bus.br_target = tgt;
      bus.trap_req  = trp;
      model_step(r, stl, rdy, br, tgt, trp);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, req);
      end
   endtask

   // Monitor: one prediction per clock edge, compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc",       bus.pc,                 e.pc);
            chk("pc_valid", {31'b0, bus.pc_valid},  {31'b0, e.valid});
            chk("pc_plus4", bus.pc_plus4,           e.pc + 32'd4);
            chk("misalign", {31'b0, bus.misalign},  {31'b0, e.mis});
         end
      end
   end

   initial begin
      logic [31:0] t;
      rst = 1'b1;
      bus.stall = 1'b0; bus.pc_ready = 1'b0; bus.br_taken = 1'b0;
      bus.br_target = '0; bus.trap_req = 1'b0;

      // Reset, boot cycle, then sequential fetch
      cyc(1, 0, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0);

      // Unstalled branch: pc is 0x10 here
      cyc(0, 0, 1, 1, 32'h200, 0);
      cyc(0, 0, 1, 0, 0, 0);

      // Stalled redirects, newest wins once stall drops
      cyc(0, 1, 1, 1, 32'h300, 0);
      cyc(0, 1, 1, 1, 32'h340, 0);
      cyc(0, 1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);

      // Misaligned branch, then trap colliding with a branch
      cyc(0, 0, 1, 1, 32'h202, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 32'h500, 1);
      cyc(0, 1, 0, 1, 32'h600, 1);
      cyc(0, 0, 1, 0, 0, 0);

      // Address wrap and held pc while imem is not ready
      cyc(0, 0, 1, 1, 32'hFFFF_FFFC, 0);
      cyc(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);

      // Reset while a redirect is pending
      cyc(0, 1, 1, 1, 32'h400, 0);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0)
            t = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
         else
            t = $urandom & 32'hFFFF_FFFC;
         cyc(($urandom_range(0, 49) == 0),
             ($urandom_range(0, 9) < 3),
             ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 9) == 0),
             t,
             ($urandom_range(0, 39) == 0));
      end
      cyc(0, 0, 1, 0, 0, 0);

      @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
